// File: rtl/bsg_manycore_vscale_trace_pkg.sv
// Shared types for the vscale writeback trace checker.
package bsg_manycore_vscale_trace_pkg;

    localparam int unsigned RegW  = 5;
    localparam int unsigned DataW = 32;

    // One expected writeback: destination register and data.
    typedef struct packed {
        logic [RegW-1:0]  rd;
        logic [DataW-1:0] data;
    } wb_rec_s;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISMATCH  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

endpackage

// File: rtl/bsg_manycore_vscale_wb_exp_fifo.sv
// Expected-record FIFO: els_p-entry, one read and one write port, head always visible.
module bsg_manycore_vscale_wb_exp_fifo
    import bsg_manycore_vscale_trace_pkg::*;
#(
    parameter int unsigned els_p = 16
) (
    input  logic    clk_i,
    input  logic    reset_n_i,
    input  logic    push_i,
    input  wb_rec_s data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output wb_rec_s head_o
);

    localparam int unsigned PtrW = $clog2(els_p);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wptr_r;
    logic [PtrW-1:0] rptr_r;
    logic [CntW-1:0] cnt_r;
    wb_rec_s         mem_r [els_p];
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (cnt_r == CntW'(els_p));
    assign empty_o = (cnt_r == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_r[rptr_r];

    // Pointer and occupancy update; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (push_ok) wptr_r <= wptr_r + PtrW'(1);
            if (pop_ok)  rptr_r <= rptr_r + PtrW'(1);
            cnt_r <= cnt_r + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_vscale_wb_trace_checker.sv
// In-order checker of vscale writeback events against a golden record list.
// Optional watchdog: define VSCALE_WB_CHECK_TIMEOUT_EN.
module bsg_manycore_vscale_wb_trace_checker
    import bsg_manycore_vscale_trace_pkg::*;
#(
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 4,
    parameter int unsigned els_p          = 16,
    parameter int unsigned count_width_p  = 32,
    parameter int unsigned timeout_p      = 4096
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      freeze_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      wr_reg_WB_i,
    input  logic [RegW-1:0]           reg_to_wr_WB_i,
    input  logic [DataW-1:0]          wb_data_WB_i,
    input  logic                      stall_WB_i,
    input  logic                      exp_v_i,
    input  logic [RegW-1:0]           exp_reg_i,
    input  logic [DataW-1:0]          exp_data_i,
    output logic                      exp_ready_o,
    input  logic                      exp_done_i,
    output logic                      done_o,
    output logic                      error_o,
    output logic [1:0]                err_code_o,
    output logic [RegW-1:0]           err_reg_o,
    output logic [DataW-1:0]          err_data_o,
    output logic [count_width_p-1:0]  match_count_o
);

    state_e                   state_r, state_n;
    err_code_e                err_code_r, err_code_n;
    logic [RegW-1:0]          err_reg_r, err_reg_n;
    logic [DataW-1:0]         err_data_r, err_data_n;
    logic [count_width_p-1:0] match_count_r;

    logic    obs_c, pop_c, inc_c, timeout_c;
    logic    full, empty;
    wb_rec_s head, push_rec;

    assign obs_c    = wr_reg_WB_i & ~stall_WB_i & (reg_to_wr_WB_i != '0) & ~freeze_i;
    assign push_rec = '{rd: exp_reg_i, data: exp_data_i};

    bsg_manycore_vscale_wb_exp_fifo #(.els_p(els_p)) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (exp_v_i & exp_ready_o),
        .data_i    (push_rec),
        .pop_i     (pop_c),
        .full_o    (full),
        .empty_o   (empty),
        .head_o    (head)
    );

`ifdef VSCALE_WB_CHECK_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(timeout_p + 1);
    logic [WdW-1:0] wd_r;
    logic           wd_inc_c;

    assign wd_inc_c  = (state_r == ST_RUN) & ~obs_c & ~empty & ~freeze_i;
    assign timeout_c = wd_inc_c & (wd_r == WdW'(timeout_p - 1));

    // Watchdog: counts idle cycles while records wait at the head.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)    wd_r <= '0;
        else if (wd_inc_c) wd_r <= wd_r + WdW'(1);
        else               wd_r <= '0;
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state, pop and first-error capture.
    always_comb begin
        state_n    = state_r;
        err_code_n = err_code_r;
        err_reg_n  = err_reg_r;
        err_data_n = err_data_r;
        pop_c      = 1'b0;
        inc_c      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (obs_c) begin
                    if (empty) begin
                        state_n    = ST_ERROR;
                        err_code_n = ERR_UNDERFLOW;
                        err_reg_n  = reg_to_wr_WB_i;
                        err_data_n = wb_data_WB_i;
                    end else begin
                        pop_c = 1'b1;
                        if (head.rd == reg_to_wr_WB_i && head.data == wb_data_WB_i) begin
                            inc_c = 1'b1;
                        end else begin
                            state_n    = ST_ERROR;
                            err_code_n = ERR_MISMATCH;
                            err_reg_n  = reg_to_wr_WB_i;
                            err_data_n = wb_data_WB_i;
                        end
                    end
                end else if (timeout_c) begin
                    state_n    = ST_ERROR;
                    err_code_n = ERR_TIMEOUT;
                    err_reg_n  = '0;
                    err_data_n = '0;
                end else if (exp_done_i && empty) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (obs_c) begin
                    state_n    = ST_ERROR;
                    err_code_n = ERR_UNDERFLOW;
                    err_reg_n  = reg_to_wr_WB_i;
                    err_data_n = wb_data_WB_i;
                end
            end
            default: ;
        endcase
    end

    // State, error latches and saturating match counter; reports the first error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_RUN;
            err_code_r    <= ERR_NONE;
            err_reg_r     <= '0;
            err_data_r    <= '0;
            match_count_r <= '0;
        end else begin
            state_r    <= state_n;
            err_code_r <= err_code_n;
            err_reg_r  <= err_reg_n;
            err_data_r <= err_data_n;
            if (inc_c && match_count_r != '1) match_count_r <= match_count_r + count_width_p'(1);
            if (state_r != ST_ERROR && state_n == ST_ERROR)
                $display("wb_trace_checker x=%0d y=%0d: code=%0d exp reg=%0d data=%h obs reg=%0d data=%h",
                         my_x_i, my_y_i, err_code_n, head.rd, head.data, err_reg_n, err_data_n);
        end
    end

    assign exp_ready_o   = ~full & (state_r == ST_RUN);
    assign done_o        = (state_r == ST_DONE);
    assign error_o       = (state_r == ST_ERROR);
    assign err_code_o    = err_code_r;
    assign err_reg_o     = err_reg_r;
    assign err_data_o    = err_data_r;
    assign match_count_o = match_count_r;

endmodule

// File: tb/tb_bsg_manycore_vscale_wb_trace_checker.sv
// Directed bench for the vscale writeback trace checker.
module tb_bsg_manycore_vscale_wb_trace_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        freeze = 1'b0;
    logic [3:0]  my_x = 4'd2;
    logic [3:0]  my_y = 4'd3;
    logic        wr_reg = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        stall = 1'b0;
    logic        exp_v = 1'b0;
    logic [4:0]  exp_reg = '0;
    logic [31:0] exp_data = '0;
    logic        exp_ready;
    logic        exp_done = 1'b0;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [4:0]  err_reg;
    logic [31:0] err_data;
    logic [31:0] match_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bsg_manycore_vscale_wb_trace_checker #(
        .x_cord_width_p(4), .y_cord_width_p(4), .els_p(16),
        .count_width_p(32), .timeout_p(8)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze),
        .my_x_i(my_x), .my_y_i(my_y),
        .wr_reg_WB_i(wr_reg), .reg_to_wr_WB_i(wb_reg), .wb_data_WB_i(wb_data),
        .stall_WB_i(stall),
        .exp_v_i(exp_v), .exp_reg_i(exp_reg), .exp_data_i(exp_data),
        .exp_ready_o(exp_ready), .exp_done_i(exp_done),
        .done_o(done), .error_o(error), .err_code_o(err_code),
        .err_reg_o(err_reg), .err_data_o(err_data), .match_count_o(match_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; freeze = 1'b0; wr_reg = 1'b0; stall = 1'b0;
        exp_v = 1'b0; exp_done = 1'b0;
        #2;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        exp_v = 1'b1; exp_reg = r; exp_data = d;
        step();
        exp_v = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d, input logic stl, input logic frz);
        wr_reg = 1'b1; wb_reg = r; wb_data = d; stall = stl; freeze = frz;
        step();
        wr_reg = 1'b0; stall = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%0d want=0", error); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0d want=0", done); end
        n_cmp++; if (exp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%0d want=1", exp_ready); end
        n_cmp++; if (match_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", match_count); end
        n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_code got=%0d want=0", err_code); end
        do_reset();
    endtask

    task automatic test_match();
        do_reset();
        push(5'd5, 32'h11);
        push(5'd6, 32'h22);
        wb(5'd5, 32'h11, 1'b0, 1'b0);
        n_cmp++; if (match_count !== 32'd1) begin n_bad++; $display("FAIL match_count1 got=%0d want=1", match_count); end
        wb(5'd6, 32'h22, 1'b0, 1'b0);
        n_cmp++; if (match_count !== 32'd2) begin n_bad++; $display("FAIL match_count2 got=%0d want=2", match_count); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL match_error got=%0d want=0", error); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL match_early_done got=%0d want=0", done); end
        exp_done = 1'b1;
        step();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL match_done got=%0d want=1", done); end
        n_cmp++; if (exp_ready !== 1'b0) begin n_bad++; $display("FAIL done_ready got=%0d want=0", exp_ready); end
        exp_done = 1'b0;
        wb(5'd7, 32'h77, 1'b0, 1'b0);
        n_cmp++; if (err_code !== 2'd2 || error !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL done_late_wb code=%0d err=%0d done=%0d want 2/1/0", err_code, error, done); end
    endtask

    task automatic test_mismatch();
        do_reset();
        push(5'd5, 32'h11);
        wb(5'd5, 32'h12, 1'b0, 1'b0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL mm_error got=%0d want=1", error); end
        n_cmp++; if (err_code !== 2'd1) begin n_bad++; $display("FAIL mm_code got=%0d want=1", err_code); end
        n_cmp++; if (err_reg !== 5'd5) begin n_bad++; $display("FAIL mm_reg got=%0d want=5", err_reg); end
        n_cmp++; if (err_data !== 32'h12) begin n_bad++; $display("FAIL mm_data got=%h want=12", err_data); end
        n_cmp++; if (exp_ready !== 1'b0) begin n_bad++; $display("FAIL mm_ready got=%0d want=0", exp_ready); end
        n_cmp++; if (match_count !== 32'd0) begin n_bad++; $display("FAIL mm_count got=%0d want=0", match_count); end
        wb(5'd9, 32'h99, 1'b0, 1'b0);
        n_cmp++; if (err_code !== 2'd1 || err_reg !== 5'd5 || err_data !== 32'h12) begin
            n_bad++; $display("FAIL mm_held code=%0d reg=%0d data=%h want 1/5/12", err_code, err_reg, err_data); end
    endtask

    task automatic test_underflow();
        do_reset();
        exp_v = 1'b1; exp_reg = 5'd3; exp_data = 32'h7;
        wb(5'd3, 32'h7, 1'b0, 1'b0);
        exp_v = 1'b0;
        n_cmp++; if (error !== 1'b1 || err_code !== 2'd2) begin
            n_bad++; $display("FAIL uf_code err=%0d code=%0d want 1/2", error, err_code); end
        n_cmp++; if (err_reg !== 5'd3 || err_data !== 32'h7) begin
            n_bad++; $display("FAIL uf_capture reg=%0d data=%h want 3/7", err_reg, err_data); end
    endtask

    task automatic test_ignored_and_full();
        do_reset();
        push(5'd4, 32'h44);
        wb(5'd0, 32'h44, 1'b0, 1'b0);
        wb(5'd4, 32'h44, 1'b1, 1'b0);
        wb(5'd4, 32'h44, 1'b0, 1'b1);
        n_cmp++; if (match_count !== 32'd0 || error !== 1'b0) begin
            n_bad++; $display("FAIL ignored count=%0d err=%0d want 0/0", match_count, error); end
        wb(5'd4, 32'h44, 1'b0, 1'b0);
        n_cmp++; if (match_count !== 32'd1) begin n_bad++; $display("FAIL ignored_then_match got=%0d want=1", match_count); end
        freeze = 1'b1;
        for (int i = 0; i < 16; i++) push(5'(i + 1), 32'hA000_0000 + 32'(i));
        n_cmp++; if (exp_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%0d want=0", exp_ready); end
        exp_v = 1'b1; exp_reg = 5'd20; exp_data = 32'hDEAD;
        step();
        step();
        exp_v = 1'b0;
        n_cmp++; if (exp_ready !== 1'b0 || error !== 1'b0) begin
            n_bad++; $display("FAIL full_hold ready=%0d err=%0d want 0/0", exp_ready, error); end
        freeze = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_reg = 1'b1; wb_reg = 5'(i + 1); wb_data = 32'hA000_0000 + 32'(i);
            step();
        end
        wr_reg = 1'b0;
        n_cmp++; if (match_count !== 32'd17 || error !== 1'b0) begin
            n_bad++; $display("FAIL drain count=%0d err=%0d want 17/0", match_count, error); end
        n_cmp++; if (exp_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready got=%0d want=1", exp_ready); end
        wb(5'd20, 32'hDEAD, 1'b0, 1'b0);
        n_cmp++; if (err_code !== 2'd2) begin n_bad++; $display("FAIL held_17th code=%0d want=2", err_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        push(5'd9, 32'h99);
        repeat (5) step();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL to_early err=%0d want=0", error); end
        repeat (10) step();
`ifdef VSCALE_WB_CHECK_TIMEOUT_EN
        n_cmp++; if (error !== 1'b1 || err_code !== 2'd3) begin
            n_bad++; $display("FAIL to_code err=%0d code=%0d want 1/3", error, err_code); end
        n_cmp++; if (err_reg !== 5'd0 || err_data !== 32'd0) begin
            n_bad++; $display("FAIL to_capture reg=%0d data=%h want 0/0", err_reg, err_data); end
`else
        n_cmp++; if (error !== 1'b0 || err_code !== 2'd0) begin
            n_bad++; $display("FAIL no_to err=%0d code=%0d want 0/0", error, err_code); end
        wb(5'd9, 32'h99, 1'b0, 1'b0);
        n_cmp++; if (match_count !== 32'd1) begin n_bad++; $display("FAIL no_to_match got=%0d want=1", match_count); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(5'd1, 32'h1);
        push(5'd2, 32'h2);
        push(5'd3, 32'h3);
        wb(5'd1, 32'h1, 1'b0, 1'b0);
        wb(5'd2, 32'hBAD, 1'b0, 1'b0);
        n_cmp++; if (error !== 1'b1 || match_count !== 32'd1) begin
            n_bad++; $display("FAIL pre_rst err=%0d count=%0d want 1/1", error, match_count); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (error !== 1'b0 || match_count !== 32'd0 || err_code !== 2'd0) begin
            n_bad++; $display("FAIL async_rst err=%0d count=%0d code=%0d want 0/0/0", error, match_count, err_code); end
        n_cmp++; if (exp_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_ready got=%0d want=1", exp_ready); end
        step();
        reset_n = 1'b1;
        step();
        wb(5'd3, 32'h3, 1'b0, 1'b0);
        n_cmp++; if (err_code !== 2'd2) begin n_bad++; $display("FAIL rst_fifo_empty code=%0d want=2", err_code); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_underflow();
        test_ignored_and_full();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
